gray_conv_sched: RTL and testbench

- Sequencer/arbiter that shares one bit-serial Gray-to-binary converter among NREQ requesters.
- Arbitrates requests, captures the winner's Gray code, and decodes it MSB-first at one bit per cycle.
- Presents the binary result with a valid/ready handshake.
- Sits between Gray-coded sources (encoder positions, pointer snapshots) and binary consumers, replacing per-source parallel XOR chains.

---
 rtl/gray_conv_pkg.sv | 23 ++
 rtl/gray_conv_sched_arb.sv | 52 +++++
 rtl/gray_conv_sched.sv | 152 +++++++++++++++
 tb/tb_gray_conv_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the gray_conv_sched slice: FSM state type,
// the out_id width function and a parallel Gray-to-binary reference.
package gray_conv_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  localparam int unsigned GC_MAXW = 64;

  function automatic int unsigned idw(input int unsigned nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction

  // Each binary bit is the XOR of every Gray bit at or above it.
  function automatic logic [GC_MAXW-1:0] gray2bin_ref(input logic [GC_MAXW-1:0] g);
    logic [GC_MAXW-1:0] b;
    b = g;
    for (int unsigned s = 1; s < GC_MAXW; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_conv_sched_arb.sv
// One-hot request arbiter for gray_conv_sched. GRAY_CONV_RR_ARB_EN selects
// round-robin starting after 'last'; otherwise fixed priority, lowest index wins.
module rr_arbiter_onehot #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  input  logic            en,
  output logic [NREQ-1:0] grant
);

`ifdef GRAY_CONV_RR_ARB_EN
  int unsigned last_u;
  logic        found;

  always_comb begin
    grant  = '0;
    found  = 1'b0;
    last_u = int'(last);
    if (en) begin
      for (int unsigned off = 1; off <= NREQ; off++) begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          if (!found && req[i] && (i == ((last_u + off) % NREQ))) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end
  end
`else
  logic found;
  logic unused_last;

  assign unused_last = ^last;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (en) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/gray_conv_sched.sv
// Shares one bit-serial Gray-to-binary converter among NREQ requesters.
// Define GRAY_CONV_RR_ARB_EN for round-robin arbitration (default: fixed priority).
module gray_conv_sched
  import gray_conv_pkg::*;
#(
  parameter  int unsigned W    = 4,
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDW  = idw(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] gray_in,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [W-1:0]      bin_out,
  output logic [IDW-1:0]    out_id,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned CW = $clog2(W);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic            acc_q, acc_d;
  logic [W-1:0]    bin_q, bin_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic [IDW-1:0]  last_q, last_d;

  logic [NREQ-1:0] arb_grant;
  logic            arb_en;
  logic [IDW-1:0]  win_idx;
  logic [W-1:0]    win_gray;
  logic            bit_v;

  assign arb_en = (state_q == IDLE);

  rr_arbiter_onehot #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (req),
`ifdef GRAY_CONV_RR_ARB_EN
    .last  (last_q),
`else
    .last  ('0),
`endif
    .en    (arb_en),
    .grant (arb_grant)
  );

  always_comb begin
    win_idx  = '0;
    win_gray = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        win_idx  = IDW'(i);
        win_gray = gray_in[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    id_d    = id_q;
    grant_d = '0;
    valid_d = valid_q;
    busy_d  = busy_q;
    bit_v   = 1'b0;
`ifdef GRAY_CONV_RR_ARB_EN
    last_d  = last_q;
`else
    last_d  = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|arb_grant) begin
          grant_d = arb_grant;
          id_d    = win_idx;
          last_d  = win_idx;
          shreg_d = win_gray;
          acc_d   = 1'b0;
          cnt_d   = CW'(W - 1);
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        // acc holds the previous binary bit, so the MSB passes straight through.
        bit_v   = shreg_q[W-1] ^ acc_q;
        acc_d   = bit_v;
        bin_d   = {bin_q[W-2:0], bit_v};
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      acc_q   <= 1'b0;
      bin_q   <= '0;
      id_q    <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      id_q    <= id_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign bin_out   = bin_q;
  assign out_id    = id_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_gray_conv_sched.sv
// Self-checking bench for gray_conv_sched (W=4, NREQ=2) against a
// transaction-level model of arbitration, latency and handshake.
module tb_gray_conv_sched;

  localparam int unsigned W    = 4;
  localparam int unsigned NREQ = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req = '0;
  logic [7:0]   gray_in = '0;
  logic [1:0]   grant;
  logic         busy;
  logic [3:0]   bin_out;
  logic [0:0]   out_id;
  logic         out_valid;
  logic         out_ready = 1'b1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  gray_conv_sched #(.W(W), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gray_in   (gray_in),
    .grant     (grant),
    .busy      (busy),
    .bin_out   (bin_out),
    .out_id    (out_id),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [3:0] m_g2b(input logic [3:0] g);
    logic [3:0] b;
    b = '0;
    for (int unsigned s = 0; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic int m_pick(input logic [1:0] r, input int last);
    int k;
    k = -1;
`ifdef GRAY_CONV_RR_ARB_EN
    for (int off = 1; off <= NREQ; off++) begin
      if (k < 0 && r[(last + off) % NREQ]) k = (last + off) % NREQ;
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (k < 0 && r[i]) k = i;
    end
`endif
    return k;
  endfunction

  bit         m_ok = 1'b0;
  int         m_phase;       // 0 waiting for a request, 1 converting, 2 result held
  int         m_timer;
  int         m_last;
  logic [1:0] m_grant;
  logic       m_busy, m_valid;
  logic [3:0] m_bin, m_pend;
  logic [0:0] m_id;
  logic [1:0] s_req;
  logic [7:0] s_gray;
  logic       s_rdy, s_rst;
  int         k_win;

  always @(posedge clk) begin
    s_req = req; s_gray = gray_in; s_rdy = out_ready; s_rst = rst;
    cyc++;
    if (s_rst) begin
      m_ok = 1'b1; m_phase = 0; m_timer = 0; m_last = NREQ - 1;
      m_grant = '0; m_busy = 1'b0; m_valid = 1'b0; m_bin = '0; m_id = '0;
    end else if (m_ok) begin
      m_grant = '0;
      case (m_phase)
        0: begin
          k_win = m_pick(s_req, m_last);
          if (k_win >= 0) begin
            m_grant = 2'(1 << k_win);
            m_id    = 1'(k_win);
            m_last  = k_win;
            m_pend  = m_g2b(s_gray[k_win*W +: W]);
            m_timer = W;
            m_busy  = 1'b1;
            m_phase = 1;
          end
        end
        1: begin
          m_timer--;
          if (m_timer == 0) begin
            m_valid = 1'b1;
            m_bin   = m_pend;
            m_phase = 2;
          end
        end
        default: begin
          if (s_rdy) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_phase = 0;
          end
        end
      endcase
    end
    #1;
    if (m_ok) begin
      check("grant", 32'(grant), 32'(m_grant));
      check("busy", 32'(busy), 32'(m_busy));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid || s_rst) begin
        check("bin_out", 32'(bin_out), 32'(m_bin));
        check("out_id", 32'(out_id), 32'(m_id));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_grant(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (|grant) begin ok = 1'b1; break; end
    end
    if (!ok) check({name, "_grant_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check({name, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    out_ready = 1'b1;
    while ((busy || out_valid) && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (busy || out_valid) check({name, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  logic [1:0]  exp_g [3];
  logic [3:0]  exp_b [3];
  int unsigned ci [2];
  int unsigned gcyc [3];
  bit          ok;
  int          lat;

  initial begin
`ifdef GRAY_CONV_RR_ARB_EN
    exp_g = '{2'b01, 2'b10, 2'b01};
    exp_b = '{4'b0100, 4'b1101, 4'b0100};
`else
    exp_g = '{2'b01, 2'b01, 2'b01};
    exp_b = '{4'b0100, 4'b0100, 4'b0100};
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);

    // Single word from requester 0
    out_ready = 1'b1;
    gray_in[3:0] = 4'b1001;
    req = 2'b01;
    wait_grant("t1", ok);
    check("t1_grant", 32'(grant), 32'h1);
    req = 2'b00;
    wait_valid("t1", lat);
    check("t1_latency", 32'(lat), 32'(W));
    check("t1_bin", 32'(bin_out), 32'hE);
    check("t1_id", 32'(out_id), 32'd0);
    wait_idle("t1");

    // Stalled consumer holds the result
    out_ready = 1'b0;
    gray_in[7:4] = 4'b1111;
    req = 2'b10;
    wait_grant("t2", ok);
    check("t2_grant", 32'(grant), 32'h2);
    req = 2'b00;
    wait_valid("t2", lat);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 32'(out_valid), 32'd1);
      check("t2_hold_bin", 32'(bin_out), 32'hA);
      check("t2_hold_id", 32'(out_id), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_idle("t2");

    // Both requesting continuously
    gray_in = {4'b1011, 4'b0110};
    req = 2'b11;
    for (int n = 0; n < 3; n++) begin
      wait_grant("t3", ok);
      gcyc[n] = cyc;
      check("t3_grant_seq", 32'(grant), 32'(exp_g[n]));
      wait_valid("t3", lat);
      check("t3_bin", 32'(bin_out), 32'(exp_b[n]));
    end
    check("t3_spacing_a", gcyc[1] - gcyc[0], W + 2);
    check("t3_spacing_b", gcyc[2] - gcyc[1], W + 2);
    req = 2'b00;
    wait_idle("t3");

    // Reset during conversion
    gray_in[3:0] = 4'b0011;
    req = 2'b01;
    wait_grant("t4", ok);
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_rst_valid", 32'(out_valid), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_bin", 32'(bin_out), 32'd0);
    req = 2'b11;
    wait_grant("t4b", ok);
    check("t4_first_prio", 32'(grant), 32'h1);
    req = 2'b00;
    wait_idle("t4");

    // Randomised sweep of all Gray codes per requester with consumer stalls
    ci = '{0, 0};
    for (int t = 0; t < 3000; t++) begin
      if (ci[0] >= 16 && ci[1] >= 16 && req == 2'b00) break;
      @(negedge clk);
      out_ready = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < 2; k++) begin
        if (grant[k]) begin
          ci[k]++;
          req[k] = 1'b0;
        end
        if (!req[k]) begin
          if (ci[k] < 16 && $urandom_range(0, 3) == 0) begin
            gray_in[k*4 +: 4] = 4'(ci[k]);
            req[k] = 1'b1;
          end else begin
            gray_in[k*4 +: 4] = 4'($urandom);
          end
        end
      end
    end
    check("sweep_done0", ci[0], 32'd16);
    check("sweep_done1", ci[1], 32'd16);
    req = 2'b00;
    wait_idle("sweep");
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
